// File: rtl/tlb_search_arbiter.sv
// Arbitrates wb/ms/fs TLB searches onto one search port via a grant/search/response pipeline.
// Define TLB_ARB_RR_EN for round-robin ms/fs arbitration; otherwise fixed priority wb > ms > fs.
module tlb_search_arbiter #(
    parameter int unsigned TLBNUM = 16,
    parameter int unsigned IDXW   = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wb_req,
    input  logic [26:0]     wb_key,
    input  logic            ms_req,
    input  logic [26:0]     ms_key,
    input  logic            fs_req,
    input  logic [26:0]     fs_key,
    output logic [2:0]      gnt,
    output logic [2:0]      rsp_valid,
    output logic            rsp_found,
    output logic [IDXW-1:0] rsp_index,
    input  logic            tlb_we,
    input  logic            flush,
    output logic [18:0]     s_vpn2,
    output logic [7:0]      s_asid,
    input  logic            s_found,
    input  logic [IDXW-1:0] s_index
);

    if (TLBNUM != (32'd1 << IDXW)) begin : g_cfg_check
        $error("tlb_search_arbiter: TLBNUM must equal 2**IDXW");
    end

    // Bit order everywhere is {wb, ms, fs}.
    logic [2:0]  outst_q, outst_d;
    logic [2:0]  s1_own_q;
    logic [1:0]  wblk_q, wblk_eff;
    logic        blocked;
    logic [2:0]  elig;
    logic        pick_fs;
    logic [2:0]  kill, s1_live;
    logic [26:0] sel_key;

    always_comb begin
        wblk_eff = tlb_we ? 2'd2 : wblk_q;
        blocked  = (wblk_eff != 2'd0) | reset;
        elig     = {wb_req, ms_req, fs_req} & ~outst_q;
        if (flush) begin
            elig[1:0] = 2'b00;
        end
    end

`ifdef TLB_ARB_RR_EN
    logic rr_fs_q;

    assign pick_fs = elig[0] & (~elig[1] | rr_fs_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_fs_q <= 1'b0;
        end else if (gnt[1]) begin
            rr_fs_q <= 1'b1;
        end else if (gnt[0]) begin
            rr_fs_q <= 1'b0;
        end
    end
`else
    assign pick_fs = elig[0] & ~elig[1];
`endif

    always_comb begin
        gnt = 3'b000;
        if (!blocked) begin
            if (elig[2]) begin
                gnt = 3'b100;
            end else if (pick_fs) begin
                gnt = 3'b001;
            end else if (elig[1]) begin
                gnt = 3'b010;
            end
        end

        sel_key = fs_key;
        if (gnt[2]) begin
            sel_key = wb_key;
        end else if (gnt[1]) begin
            sel_key = ms_key;
        end

        // A write invalidates any search in flight; a flush kills only ms/fs searches.
        kill    = s1_own_q & ({3{tlb_we}} | {1'b0, flush, flush});
        s1_live = s1_own_q & ~kill;
        outst_d = (outst_q | gnt) & ~kill & ~rsp_valid;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outst_q   <= 3'b000;
            s1_own_q  <= 3'b000;
            wblk_q    <= 2'd0;
            rsp_valid <= 3'b000;
            rsp_found <= 1'b0;
            rsp_index <= '0;
            s_vpn2    <= 19'd0;
            s_asid    <= 8'd0;
        end else begin
            outst_q   <= outst_d;
            s1_own_q  <= gnt;
            rsp_valid <= s1_live;
            wblk_q    <= blocked ? wblk_eff - 2'd1 : 2'd0;
            if (|gnt) begin
                {s_vpn2, s_asid} <= sel_key;
            end
            if (|s1_live) begin
                rsp_found <= s_found;
                rsp_index <= s_index;
            end
        end
    end

endmodule

// File: tb/tb_tlb_search_arbiter.sv
// Scoreboard bench for tlb_search_arbiter: a transaction-level requester/TLB model predicts
// grants and responses; a monitor pops expected responses whenever rsp_valid is seen.
module tb_tlb_search_arbiter;

`ifdef TLB_ARB_RR_EN
    localparam bit RrMode = 1'b1;
`else
    localparam bit RrMode = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_req, ms_req, fs_req;
    logic [26:0] wb_key, ms_key, fs_key;
    logic [2:0]  gnt, rsp_valid;
    logic        rsp_found;
    logic [3:0]  rsp_index;
    logic        tlb_we, flush;
    logic [18:0] s_vpn2;
    logic [7:0]  s_asid;
    logic        s_found;
    logic [3:0]  s_index;

    tlb_search_arbiter #(.TLBNUM(16), .IDXW(4)) dut (
        .clk(clk), .reset(reset),
        .wb_req(wb_req), .wb_key(wb_key),
        .ms_req(ms_req), .ms_key(ms_key),
        .fs_req(fs_req), .fs_key(fs_key),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_found(rsp_found), .rsp_index(rsp_index),
        .tlb_we(tlb_we), .flush(flush),
        .s_vpn2(s_vpn2), .s_asid(s_asid), .s_found(s_found), .s_index(s_index)
    );

    always #5 clk = ~clk;

    // TLB contents: entry 7 holds {19'h00012, 8'h05}.
    logic [18:0] tv [16];
    logic [7:0]  ta [16];
    initial begin
        for (int i = 0; i < 16; i++) begin
            tv[i] = 19'h0000b + 19'(i);
            ta[i] = 8'(i) ^ 8'h02;
        end
    end

    always_comb begin
        s_found = 1'b0;
        s_index = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (tv[i] == s_vpn2 && ta[i] == s_asid) begin
                s_found = 1'b1;
                s_index = 4'(i);
            end
        end
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: cycle %0d got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    typedef struct {
        int         who;
        int         due;
        bit         found;
        logic [3:0] idx;
    } rsp_t;
    rsp_t sb[$];

    // Requester/model state, index 2=wb, 1=ms, 0=fs.
    bit          act [3];
    logic [26:0] key [3];
    bit          busy [3];
    int          job_due [3];
    bit          pref_fs;
    int          last_we;
    logic [26:0] exp_skey;

    function automatic logic [4:0] lookup(input logic [26:0] k);
        logic [4:0] r = 5'd0;
        for (int i = 0; i < 16; i++) begin
            if ({tv[i], ta[i]} == k) r = {1'b1, 4'(i)};
        end
        return r;
    endfunction

    function automatic logic [26:0] rand_key();
        int i = $urandom_range(0, 15);
        if ($urandom_range(0, 1) == 1) return {tv[i], ta[i]};
        return 27'($urandom);
    endfunction

    task automatic model_clear();
        for (int w = 0; w < 3; w++) begin
            act[w] = 1'b0; busy[w] = 1'b0; job_due[w] = -1;
        end
        sb.delete();
        pref_fs  = 1'b0;
        last_we  = -10;
        exp_skey = 27'd0;
    endtask

    // One cycle: drive inputs at the negedge, predict and check the grant, advance the model.
    task automatic step(input bit we, input bit fl);
        bit         blocked;
        bit [2:0]   el;
        logic [2:0] eg;
        int         g;
        logic [4:0] lk;
        wb_req = act[2]; wb_key = key[2];
        ms_req = act[1]; ms_key = key[1];
        fs_req = act[0]; fs_key = key[0];
        tlb_we = we; flush = fl;
        #1;
        blocked = we || (cyc == last_we + 1);
        for (int w = 0; w < 3; w++) el[w] = act[w] && !busy[w];
        if (fl) el[1:0] = 2'b00;
        eg = 3'b000; g = -1;
        if (!blocked) begin
            if (el[2]) g = 2;
            else if (el[1] && el[0]) g = (RrMode && pref_fs) ? 0 : 1;
            else if (el[1]) g = 1;
            else if (el[0]) g = 0;
        end
        if (g >= 0) eg = 3'(32'd1 << g);
        chk("gnt", 32'(gnt), 32'(eg));
        chk("s_key", 32'({s_vpn2, s_asid}), 32'(exp_skey));
        for (int w = 0; w < 3; w++) begin
            if (job_due[w] == cyc + 1 && (we || (fl && w != 2))) begin
                job_due[w] = -1;
                busy[w] = 1'b0;
                for (int j = 0; j < sb.size(); j++) begin
                    if (sb[j].due == cyc + 1) begin
                        sb.delete(j);
                        break;
                    end
                end
            end
            if (job_due[w] == cyc) begin
                job_due[w] = -1;
                busy[w] = 1'b0;
                act[w] = 1'b0;
            end
        end
        if (g >= 0) begin
            busy[g] = 1'b1;
            job_due[g] = cyc + 2;
            exp_skey = key[g];
            lk = lookup(key[g]);
            sb.push_back('{who: g, due: cyc + 2, found: lk[4], idx: lk[3:0]});
            if (g != 2) pref_fs = (g == 1);
        end
        if (we) last_we = cyc;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    rsp_t mon_e;
    bit   last_f;
    logic [3:0] last_i;

    always @(negedge clk) begin
        #2;
        if (reset) begin
            last_f = 1'b0;
            last_i = 4'd0;
        end else begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                mon_e = sb.pop_front();
                total++;
                bad++;
                $display("FAIL rsp_missing: requester %0d due %0d got no response",
                         mon_e.who, mon_e.due);
            end
            if (rsp_valid != 3'b000) begin
                if (sb.size() == 0 || sb[0].due != cyc) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rsp_valid", 32'(rsp_valid), 32'd1 << mon_e.who);
                    chk("rsp_found", 32'(rsp_found), 32'(mon_e.found));
                    chk("rsp_index", 32'(rsp_index), 32'(mon_e.idx));
                    last_f = mon_e.found;
                    last_i = mon_e.idx;
                end
            end else begin
                chk("rsp_found_hold", 32'(rsp_found), 32'(last_f));
                chk("rsp_index_hold", 32'(rsp_index), 32'(last_i));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish, got running want done");
        $fatal(1, "timeout");
    end

    initial begin
        model_clear();
        reset = 1'b1;
        tlb_we = 1'b0; flush = 1'b0;
        wb_req = 1'b1; ms_req = 1'b1; fs_req = 1'b1;
        wb_key = 27'h1234567; ms_key = 27'h0abcdef; fs_key = 27'h7654321;
        key[0] = 27'd0; key[1] = 27'd0; key[2] = 27'd0;
        @(negedge clk); @(negedge clk);
        #1;
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_found", 32'(rsp_found), 32'd0);
        chk("reset_rsp_index", 32'(rsp_index), 32'd0);
        chk("reset_s_vpn2", 32'(s_vpn2), 32'd0);
        chk("reset_s_asid", 32'(s_asid), 32'd0);
        wb_req = 1'b0; ms_req = 1'b0; fs_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        idle(2);

        // fs hit on entry 7.
        act[0] = 1'b1; key[0] = {19'h00012, 8'h05};
        idle(6);

        // All three at once: wb, ms, fs in successive cycles.
        for (int w = 0; w < 3; w++) begin
            act[w] = 1'b1; key[w] = rand_key();
        end
        idle(8);

        // ms in search stage when a TLB write arrives.
        act[1] = 1'b1; key[1] = {tv[3], ta[3]};
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        idle(7);

        // fs in search stage when a flush arrives.
        act[0] = 1'b1; key[0] = {tv[9], ta[9]};
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        idle(6);

        // ms and fs requesting continuously.
        key[1] = {tv[1], ta[1]}; key[0] = {tv[2], ta[2]};
        for (int i = 0; i < 12; i++) begin
            act[1] = 1'b1; act[0] = 1'b1;
            step(1'b0, 1'b0);
        end
        idle(6);

        // Asynchronous reset while an fs search is in flight.
        act[0] = 1'b1; key[0] = {tv[5], ta[5]};
        step(1'b0, 1'b0);
        #3 reset = 1'b1;
        #1;
        chk("areset_gnt", 32'(gnt), 32'd0);
        chk("areset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("areset_rsp_found", 32'(rsp_found), 32'd0);
        chk("areset_rsp_index", 32'(rsp_index), 32'd0);
        chk("areset_s_vpn2", 32'(s_vpn2), 32'd0);
        chk("areset_s_asid", 32'(s_asid), 32'd0);
        model_clear();
        wb_req = 1'b0; ms_req = 1'b0; fs_req = 1'b0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        idle(6);

        // Randomised traffic with writes and flushes.
        for (int i = 0; i < 3000; i++) begin
            for (int w = 0; w < 3; w++) begin
                if (!act[w] && $urandom_range(0, 2) == 0) begin
                    act[w] = 1'b1;
                    key[w] = rand_key();
                end
            end
            step($urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);
        end
        idle(8);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
